// File: rtl/out_uart_tx.sv
// out_uart_tx: watches the core's 8-bit debug output, queues every new byte
// in a small circular FIFO and sends it as an 8N1 UART frame on tx_o.
// A byte is queued whenever data_i differs from the previous cycle's value
// or force_i is high. The line idles high.
// Optional build macro UART_PARITY_EN: adds an even-parity bit between the
// data bits and the stop bit (8E1 framing).
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  data_i,
    input  logic                        force_i,
    input  logic                        clear_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Capture and queue state
    logic [7:0]       prev_q;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             busy_q;

    // Transmitter state
    state_t           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;
    logic baud_last;

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push  = (data_i != prev_q) | force_i;
    assign pop   = (state_q == S_IDLE) && (level_q != '0);
    assign full  = (level_q == LVL_FULL);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign baud_last = (baud_q == BAUD_LAST);

    // Change detector, FIFO pointers/level, sticky overflow and busy flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            prev_q <= data_i;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
            busy_q <= (state_q != S_IDLE) || (level_q != '0);
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; the level counter and pointers
        // already mark every entry invalid, so clearing the data is wasted logic.
        if (wr_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Transmitter next-state, counters, shift register and next line level.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
`ifdef UART_PARITY_EN
                    parity_d = ^mem[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Line level is decided from the next state so tx_o comes straight
        // from a flop and changes on the same edge as the state.
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Transmitter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Self-checking bench for out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based model predicts every output each cycle; a small UART
// receiver decodes the line so whole bytes can be checked against literals.
module tb_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic [7:0] data_i  = 8'h00;
    logic       force_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_level_o;
    logic       overflow_o;

    out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .force_i     (force_i),
        .clear_i     (clear_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .fifo_level_o(fifo_level_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of waiting bytes, plus the list of line levels still to be driven
    // for the frame in flight (ending with the mandatory idle cycle).
    logic [7:0] m_q[$];
    bit         m_wave[$];
    logic [7:0] m_prev  = 8'h00;
    bit         m_ov    = 1'b0;
    bit         m_tx    = 1'b1;
    bit         m_busy  = 1'b0;
    int         m_level = 0;
    bit         m_was_idle, m_push, m_pop, m_drop;
    int         m_old_lvl;
    logic [7:0] m_byte;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_q.delete();
            m_wave.delete();
            m_prev  = 8'h00;
            m_ov    = 1'b0;
            m_tx    = 1'b1;
            m_busy  = 1'b0;
            m_level = 0;
        end else begin
            m_was_idle = (m_wave.size() == 0);
            m_old_lvl  = m_q.size();
            m_busy     = !m_was_idle || (m_old_lvl != 0);
            m_push     = (data_i != m_prev) || force_i;
            m_prev     = data_i;
            m_pop      = m_was_idle && (m_old_lvl != 0);
            m_drop     = 1'b0;
            if (m_pop) begin
                m_byte = m_q.pop_front();
                repeat (CPB) m_wave.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CPB) m_wave.push_back(m_byte[i]);
`ifdef UART_PARITY_EN
                repeat (CPB) m_wave.push_back(^m_byte);
`endif
                repeat (CPB) m_wave.push_back(1'b1);
                m_wave.push_back(1'b1);
            end
            if (m_push) begin
                if (m_old_lvl < DEPTH || m_pop) m_q.push_back(data_i);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ov = 1'b1;
            else if (clear_i) m_ov = 1'b0;
            m_tx    = (m_wave.size() != 0) ? m_wave.pop_front() : 1'b1;
            m_level = m_q.size();
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_i) begin
        check("tx", tx_o, m_tx);
        check("busy", busy_o, m_busy);
        check("level", fifo_level_o, m_level);
        check("overflow", overflow_o, m_ov);
    end

    // ---------------- line receiver ----------------
    logic [7:0] rx_q[$];
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_active = 1'b0;
            rx_cnt    = 0;
        end else if (!rx_active) begin
            if (tx_o == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_byte   = 8'h00;
            end
        end else begin
            rx_cnt++;
            for (int i = 0; i < 8; i++)
                if (rx_cnt == CPB * (1 + i) + CPB / 2) rx_byte[i] = tx_o;
`ifdef UART_PARITY_EN
            if (rx_cnt == CPB * 9 + CPB / 2) check("rx_parity", tx_o, ^rx_byte);
`endif
            if (rx_cnt == CPB * (NSYM - 1) + CPB / 2) begin
                check("rx_stop", tx_o, 1);
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (2) @(negedge clk_i);
        while (busy_o === 1'b1 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_within_budget", n < budget, 1);
    endtask

    bit         wv[60];
    bit         bz[60];
    logic [2:0] lv0;
    int         busy_cnt;
    logic [10:0] exp_frame;

    initial begin
        // Reset values, checked while reset is held.
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_overflow", overflow_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Idle with data held at 00: nothing may be sent.
        repeat (100) @(negedge clk_i);
        check("idle_no_frames", rx_q.size(), 0);

        // Single byte A5: exact waveform and busy duration.
`ifdef UART_PARITY_EN
        exp_frame = 11'b1_0_1010_0101_0;
`else
        exp_frame = 11'b0_1_1010_0101_0;
`endif
        data_i = 8'hA5;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            wv[k] = tx_o;
            bz[k] = busy_o;
            if (k == 0) lv0 = fifo_level_o;
        end
        check("a5_level_after_push", lv0, 1);
        check("a5_idle_before_pop", wv[0], 1);
        check("a5_start_at_e1", wv[1], 0);
        for (int j = 0; j < NSYM; j++) check("a5_symbol", wv[1 + CPB * j + CPB / 2], exp_frame[j]);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) busy_cnt += bz[k];
        check("a5_busy_cycles", busy_cnt, NSYM * CPB + 1);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("a5_rx_byte", rx_q.pop_front(), 8'hA5);

        // Burst 01..06: FIFO fills, 06 is dropped.
        wait_idle(200);
        rx_q.delete();
        for (int v = 1; v <= 6; v++) begin
            @(negedge clk_i);
            data_i = 8'(v);
        end
        @(posedge clk_i);
        #1;
        check("burst_overflow_set", overflow_o, 1);
        check("burst_level_full", fifo_level_o, 4);
        repeat (3) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("burst_overflow_cleared", overflow_o, 0);
        wait_idle(1000);
        check("burst_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) check("burst_rx_byte", rx_q[i], i + 1);

        // Forced repeats of an unchanged byte.
        @(negedge clk_i);
        data_i = 8'h3C;
        wait_idle(200);
        rx_q.delete();
        @(negedge clk_i) force_i = 1'b1;
        @(negedge clk_i) force_i = 1'b0;
        @(negedge clk_i) force_i = 1'b1;
        @(negedge clk_i) force_i = 1'b0;
        wait_idle(1000);
        check("force_rx_count", rx_q.size(), 2);
        for (int i = 0; i < 2 && i < rx_q.size(); i++) check("force_rx_byte", rx_q[i], 8'h3C);

        // Reset in the middle of a frame with two bytes queued.
        rx_q.delete();
        @(negedge clk_i) data_i = 8'h11;
        @(negedge clk_i) data_i = 8'h22;
        @(negedge clk_i) data_i = 8'h33;
        @(posedge clk_i);
        #1;
        check("midrst_level_before", fifo_level_o, 2);
        repeat (13) @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_tx_low_before", tx_o, 0);
        #1;
        rst_i  = 1'b1;
        data_i = 8'h00;
        #1;
        check("midrst_tx", tx_o, 1);
        check("midrst_level", fifo_level_o, 0);
        check("midrst_busy", busy_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (100) @(negedge clk_i);
        check("midrst_no_frames", rx_q.size(), 0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 99) < 25) data_i = 8'($urandom);
            force_i = ($urandom_range(0, 9) == 0);
            clear_i = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk_i);
        force_i = 1'b0;
        clear_i = 1'b0;
        wait_idle(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Downstream consumer of the core's 8-bit debug output (the a0[7:0] byte exported by the CPU top).
- Detects each new output byte, queues it in a small FIFO and serialises it as 8N1 UART on a single pin, so program output reaches a host without probing the bus.
- Runs in the core's clock domain and sits beside the CPU top in the board wrapper.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; must be >= 2.
- FIFO_DEPTH, 4, byte entries in the queue; must be a power of 2 and >= 2.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- data_i  input  8  byte from the CPU output port.
- force_i  input  1  enqueue data_i this cycle even if it has not changed.
- clear_i  input  1  synchronous clear of overflow_o.
- tx_o  output  1  UART serial line; idles high.
- busy_o  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current number of queued bytes.
- overflow_o  output  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset: asynchronous, takes effect immediately.
  - tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0.
  - FIFO pointers cleared; previous-byte register prev_q=8'h00; FSM in IDLE.
  - Reset mid-frame aborts the frame with no completion, and the line goes high at once.
- Capture:
  - push = (data_i != prev_q) | force_i, evaluated every cycle.
  - prev_q <= data_i every cycle.
  - A change and force_i in the same cycle produce a single push.
- FIFO: circular buffer, read and write pointers wrap modulo FIFO_DEPTH.
  - Push when full with no pop that cycle: byte dropped, level unchanged, overflow_o set.
  - Push and pop in the same cycle: both happen (level unchanged), including when full, so no drop.
  - clear_i clears overflow_o. If clear_i and a new drop occur together, set wins.
- FSM states: IDLE, START, DATA, STOP. Bit counter 0..7 and baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop into shift register, go to START, reset the baud counter.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit=0.
  - DATA: tx_o=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles; shift right after each bit; go to STOP after bit 7.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - One IDLE cycle always separates back-to-back frames.
- tx_o is driven from a register (glitch-free).
- Latency: data_i changes before edge E0 → pushed at E0 → popped at E1 → tx_o=0 from E1.
- Frame length: 10*CLKS_PER_BIT cycles, plus 1 idle cycle between frames.
- busy_o = (state != IDLE) | (fifo_level_o != 0), registered.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP. tx_o = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, plain 8N1 framing, no extra logic.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset release with data_i=8'h00 held for 100 cycles → no push; tx_o=1, busy_o=0, fifo_level_o=0 throughout.
- data_i 8'h00→8'hA5 → tx_o=0 from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles; busy_o falls after 41 cycles.
- data_i=8'h01..8'h06 on 6 consecutive cycles:
  - 8'h01 popped at E1; 8'h02..8'h05 fill the FIFO (level 4).
  - 8'h06 is dropped and overflow_o=1.
  - Serial output is exactly 01,02,03,04,05, separated by 1 idle cycle.
  - clear_i pulse → overflow_o=0.
- Hold data_i=8'h3C and pulse force_i twice, 1 cycle apart → two identical 3C frames sent back-to-back; no push on other cycles.
- Assert rst_i 15 cycles into a frame with 2 bytes queued → tx_o=1 and fifo_level_o=0 immediately; after release no frame is emitted.
- With UART_PARITY_EN, send 8'h07 → parity bit=1; send 8'h03 → parity bit=0; each frame is 44 cycles.
